// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, header sync nibble and header formatter.
// Header layout is {sync nibble, 4-bit requester id}.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [3:0] SYNC_DEF = 4'hA;

   function automatic logic [7:0] hdr_byte(input logic [3:0] sync, input logic [3:0] id);
      return {sync, id};
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, wrapping modulo N.
// any_req is low and sel is zero when no request is pending.
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = 4
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] rr_ptr,
   output logic [IW-1:0] sel,
   output logic          any_req
);

   always_comb begin
      int idx;
      sel     = '0;
      any_req = 1'b0;
      idx     = 0;
      // Scan from farthest to nearest so the nearest hit is the one that sticks.
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % N;
         if (req[idx]) begin
            sel     = IW'(idx);
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one TX FIFO between N byte streams; each packet gets a {SYNC, id} header.
// Grant 1 cycle after req; header and payload written only while fifo_full is low; grant held until last.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int         N    = 4,
   parameter int         B    = 8,
   parameter logic [3:0] SYNC = SYNC_DEF,
   parameter int         IW   = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [N-1:0]  req,
   input  logic [N*B-1:0] in_data,
   input  logic [N-1:0]  in_valid,
   input  logic [N-1:0]  in_last,
   output logic [N-1:0]  in_ready,
   output logic          fifo_wr,
   output logic [B-1:0]  fifo_wdata,
   input  logic          fifo_full,
   output logic          busy,
   output logic [IW-1:0] grant_id,
   output logic          pkt_done
);

   localparam int SW = (N > 1) ? $clog2(N) : 1;

   state_t        state, state_nxt;
   logic [IW-1:0] rr_ptr, rr_ptr_nxt;
   logic [IW-1:0] grant_nxt;
   logic [IW-1:0] pick_id;
   logic          any_req;
   logic [SW-1:0] g;
   logic [B-1:0]  data_arr [N];

   for (genvar i = 0; i < N; i++) begin : g_unpack
      assign data_arr[i] = in_data[i*B +: B];
   end

   assign g    = grant_id[SW-1:0];
   assign busy = (state != IDLE);

   rr_picker #(
      .N  (N),
      .IW (IW)
   ) u_picker (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .sel     (pick_id),
      .any_req (any_req)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
      end else begin
         state    <= state_nxt;
         rr_ptr   <= rr_ptr_nxt;
         grant_id <= grant_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      grant_nxt  = grant_id;
      fifo_wr    = 1'b0;
      fifo_wdata = '0;
      in_ready   = '0;
      pkt_done   = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               grant_nxt = pick_id;
               state_nxt = HDR;
            end
         end
         HDR: begin
            fifo_wdata = B'(hdr_byte(SYNC, grant_id));
            fifo_wr    = ~fifo_full;
            if (!fifo_full) state_nxt = DATA;
         end
         DATA: begin
            // Ready follows FIFO space only, so a stalled requester sees it while presenting a gap.
            in_ready[g] = ~fifo_full;
            fifo_wr     = in_valid[g] & ~fifo_full;
            fifo_wdata  = data_arr[g];
            if (fifo_wr && in_last[g]) begin
               pkt_done   = 1'b1;
               state_nxt  = IDLE;
               rr_ptr_nxt = (int'(grant_id) == N - 1) ? '0 : grant_id + IW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester beat queues drive the inputs, every FIFO write is logged.
// Beat encoding in the queues is {gap, last, data}; a gap entry presents in_valid low for one ready cycle.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] in_data = '0;
   logic [3:0]  in_valid = '0;
   logic [3:0]  in_last = '0;
   logic [3:0]  in_ready;
   logic        fifo_wr;
   logic [7:0]  fifo_wdata;
   logic        fifo_full = 1'b0;
   logic        busy;
   logic [3:0]  grant_id;
   logic        pkt_done;

   int checks = 0;
   int errors = 0;
   int viol = 0;
   int done_cnt = 0;
   logic [7:0] done_byte = '0;
   logic [3:0] rdy_s = '0;
   logic [3:0] vld_s = '0;

   logic [9:0] q [4][$];
   logic [7:0] wq [$];
   logic [7:0] eq [$];

   uart_tx_arbiter #(.N(4), .B(8), .SYNC(4'hA), .IW(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .fifo_wr    (fifo_wr),
      .fifo_wdata (fifo_wdata),
      .fifo_full  (fifo_full),
      .busy       (busy),
      .grant_id   (grant_id),
      .pkt_done   (pkt_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Requester model: pop the head beat after an accepted edge, then present the new head.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 4; i++) begin
         if (q[i].size() > 0 && rdy_s[i] && (vld_s[i] || q[i][0][9]))
            void'(q[i].pop_front());
      end
      for (int i = 0; i < 4; i++) begin
         req[i]           = (q[i].size() > 0);
         in_valid[i]      = (q[i].size() > 0) && !q[i][0][9];
         in_last[i]       = (q[i].size() > 0) && q[i][0][8];
         in_data[i*8 +: 8] = (q[i].size() > 0) ? q[i][0][7:0] : 8'h00;
      end
   end

   always @(negedge clk) begin
      rdy_s = in_ready;
      vld_s = in_valid;
      if (fifo_wr) begin
         wq.push_back(fifo_wdata);
         if (fifo_full) viol++;
      end
      if (pkt_done) begin
         done_cnt++;
         done_byte = fifo_wdata;
      end
      if (fifo_full && in_ready != 4'b0) viol++;
      if ((in_ready & ~(4'b0001 << grant_id)) != 4'b0) viol++;
      if (!reset_n && (fifo_wr || busy || in_ready != 4'b0)) viol++;
   end

   task automatic wait_wr(input int n);
      int cyc = 0;
      while (wq.size() < n && cyc < 300) begin
         @(posedge clk);
         cyc++;
      end
   endtask

   task automatic check_seq(input string tag);
      chk({tag, "_len"}, 32'(wq.size()), 32'(eq.size()));
      for (int i = 0; i < eq.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), (i < wq.size()) ? 32'(wq[i]) : 32'hFFFF_FFFF, 32'(eq[i]));
      wq.delete();
      eq.delete();
   endtask

   initial begin
      int d0;

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      chk("rst_fifo_wr", 32'(fifo_wr), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pkt_done", 32'(pkt_done), 32'd0);
      chk("rst_wdata", 32'(fifo_wdata), 32'd0);
      chk("rst_grant", 32'(grant_id), 32'd0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #2;

      // Contention from rr_ptr = 0, req = 1011, one-byte packets
      d0 = done_cnt;
      q[0] = '{10'h101, 10'h102};
      q[1] = '{10'h111, 10'h112};
      q[3] = '{10'h131, 10'h132};
      eq = '{8'hA0, 8'h01, 8'hA1, 8'h11, 8'hA3, 8'h31, 8'hA0, 8'h02, 8'hA1, 8'h12, 8'hA3, 8'h32};
      wait_wr(12);
      repeat (4) @(posedge clk);
      check_seq("contend");
      chk("contend_done", 32'(done_cnt - d0), 32'd6);

      // Single packet on requester 1
      d0 = done_cnt;
      q[1] = '{10'h011, 10'h122};
      eq = '{8'hA1, 8'h11, 8'h22};
      wait_wr(3);
      repeat (4) @(posedge clk);
      check_seq("single");
      chk("single_done", 32'(done_cnt - d0), 32'd1);
      chk("single_done_byte", 32'(done_byte), 32'h22);
      chk("single_grant_hold", 32'(grant_id), 32'd1);
      chk("single_idle", 32'(busy), 32'd0);

      // rr_ptr should now be 2: requester 3 wins over requester 1
      q[1] = '{10'h15A};
      q[3] = '{10'h13C};
      eq = '{8'hA3, 8'h3C, 8'hA1, 8'h5A};
      wait_wr(4);
      repeat (4) @(posedge clk);
      check_seq("rotate");

      // Gapped payload on requester 2
      q[2] = '{10'h055, 10'h200, 10'h200, 10'h166};
      eq = '{8'hA2, 8'h55, 8'h66};
      wait_wr(2);
      @(negedge clk);
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_in_ready", 32'(in_ready), 32'h4);
      chk("gap_wr", 32'(fifo_wr), 32'd0);
      wait_wr(3);
      repeat (4) @(posedge clk);
      check_seq("gapped");

      // Wrap-around: rr_ptr = 3, req = 1001
      q[0] = '{10'h10F};
      q[3] = '{10'h1F3};
      eq = '{8'hA3, 8'hF3, 8'hA0, 8'h0F};
      wait_wr(4);
      repeat (4) @(posedge clk);
      check_seq("wrap");

      // Backpressure in HDR and mid-DATA
      fifo_full = 1'b1;
      q[0] = '{10'h0B1, 10'h0B2, 10'h1B3};
      for (int c = 0; c < 20 && !busy; c++) @(posedge clk);
      repeat (5) @(posedge clk);
      chk("bp_hdr_nowr", 32'(wq.size()), 32'd0);
      chk("bp_hdr_busy", 32'(busy), 32'd1);
      #2;
      fifo_full = 1'b0;
      wait_wr(2);
      #2;
      fifo_full = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("bp_data_nowr", 32'(wq.size()), 32'd2);
      chk("bp_data_rdy", 32'(in_ready), 32'd0);
      chk("bp_data_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #2;
      fifo_full = 1'b0;
      eq = '{8'hA0, 8'hB1, 8'hB2, 8'hB3};
      wait_wr(4);
      repeat (4) @(posedge clk);
      check_seq("bp");

      // Reset mid-DATA after one of three payload bytes
      q[2] = '{10'h0C1, 10'h0C2, 10'h1C3};
      wait_wr(2);
      #2;
      reset_n = 1'b0;
      q[2].delete();
      #1;
      chk("mrst_fifo_wr", 32'(fifo_wr), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_grant", 32'(grant_id), 32'd0);
      chk("mrst_in_ready", 32'(in_ready), 32'd0);
      eq = '{8'hA2, 8'hC1};
      check_seq("mrst_pre");
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      chk("mrst_nowr", 32'(wq.size()), 32'd0);
      q[1] = '{10'h177};
      eq = '{8'hA1, 8'h77};
      wait_wr(2);
      repeat (4) @(posedge clk);
      check_seq("mrst_post");
      chk("mrst_post_grant", 32'(grant_id), 32'd1);

      chk("invariants", 32'(viol), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
